// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button conditioning stage: per-channel FSM
// state encodings and the debounce-window calculation.
package button_debouncer_pkg;

    localparam logic STATE_STABLE   = 1'b0;
    localparam logic STATE_SETTLING = 1'b1;

    // Whole-MHz clocks only; a window that rounds down to nothing still needs one cycle.
    function automatic int calc_stable_cycles(input int clock_hz, input int debounce_us);
        longint cycles;
        cycles = (longint'(clock_hz) / 64'sd1000000) * longint'(debounce_us);
        if (cycles < 64'sd1) begin
            cycles = 64'sd1;
        end
        return int'(cycles);
    endfunction

endpackage

// File: rtl/button_debouncer_debounce_channel.sv
// One debounce lane: 2-flop synchronizer, stability counter, two-state FSM, edge pulses.
// Output level moves STABLE_CYCLES+2 edges after the pin; no input-to-output combinational path.
module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter int   STABLE_CYCLES = 4,
    parameter logic INIT_LEVEL    = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic button_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;
    logic             accept;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= INIT_LEVEL;
            sync2_q <= INIT_LEVEL;
        end else begin
            sync1_q <= button_i;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        accept  = 1'b0;

        case (state_q)
            STATE_STABLE: begin
                if (sync2_q != level_q) begin
                    if (STABLE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_d = STATE_SETTLING;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                if (sync2_q == level_q) begin
                    // Bounced back before the window closed: drop the partial count silently.
                    state_d = STATE_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase

        if (accept) begin
            level_d = sync2_q;
            state_d = STATE_STABLE;
            cnt_d   = '0;
        end

        rise_d = accept & sync2_q;
        fall_d = accept & ~sync2_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= STATE_STABLE;
            cnt_q   <= '0;
            level_q <= INIT_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer: independent lanes, each giving a clean level plus rise/fall pulses.
// Fixed STABLE_CYCLES+2 edge latency per lane; no flow control, every channel samples every cycle.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int                  CHANNELS         = 2,
    parameter int                  CLOCK_FREQUENCY  = 12000000,
    parameter int                  DEBOUNCE_TIME_US = 10000,
    parameter logic [CHANNELS-1:0] INIT_LEVEL       = {CHANNELS{1'b0}}
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] button_level,
    output logic [CHANNELS-1:0] button_rise,
    output logic [CHANNELS-1:0] button_fall
);

    localparam int STABLE_CYCLES = calc_stable_cycles(CLOCK_FREQUENCY, DEBOUNCE_TIME_US);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .INIT_LEVEL    (INIT_LEVEL[g])
        ) u_channel (
            .clock    (clock),
            .reset    (reset),
            .button_i (button_in[g]),
            .level_o  (button_level[g]),
            .rise_o   (button_rise[g]),
            .fall_o   (button_fall[g])
        );
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Upstream conditioning stage for board-level push buttons and switches (reset, halt, user inputs) before they reach the rvx core instance in a board top.
- Per channel: a 2-flop synchronizer, then a counter-based stability filter.
- Outputs per channel: a clean debounced level, plus single-cycle rise and fall pulses.
- Replaces the single register stage currently used for button inputs in board tops.

Parameters:
- CHANNELS, 2, number of independent input channels.
- CLOCK_FREQUENCY, 12000000, clock frequency in Hz.
- DEBOUNCE_TIME_US, 10000, time in microseconds an input must stay stable before it is accepted.
- INIT_LEVEL, {CHANNELS{1'b0}}, reset value of each synchronizer stage and each debounced level.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- button_in  input  CHANNELS  raw asynchronous pin levels.
- button_level  output  CHANNELS  debounced levels.
- button_rise  output  CHANNELS  one-cycle pulse when a level goes 0->1.
- button_fall  output  CHANNELS  one-cycle pulse when a level goes 1->0.

Behaviour:
- Interface facts: one clock, `clock`. `reset` is asynchronous and active-high.
- STABLE_CYCLES = (CLOCK_FREQUENCY/1000000)*DEBOUNCE_TIME_US. If this evaluates to 0 it is clamped to 1.
- Counter width = $clog2(STABLE_CYCLES+1).
- Reset (asynchronous, takes effect immediately):
  - sync1, sync2 and button_level are set to INIT_LEVEL.
  - Counters clear to 0; FSM goes to STABLE.
  - button_rise and button_fall are 0.
- Synchronizer: sync1 <= button_in; sync2 <= sync1. No logic sits between the two flops.
- Each channel has an FSM with two states, STABLE and SETTLING:
  - STABLE, sync2 == level: remain in STABLE; counter = 0.
  - STABLE, sync2 != level: go to SETTLING; counter = 1. If STABLE_CYCLES == 1, accept instead (see below).
  - SETTLING, sync2 == level (bounce back): go to STABLE; counter = 0; no pulse.
  - SETTLING, sync2 != level, counter < STABLE_CYCLES-1: counter increments.
  - SETTLING, sync2 != level, counter == STABLE_CYCLES-1: accept.
- Accept: level <= sync2; the matching rise or fall pulse is registered in the same edge and lasts exactly one cycle; counter = 0; state = STABLE.
- Latency: call the first rising edge that samples the new pin value edge 1. button_level changes on edge STABLE_CYCLES+2, and the pulse is high for the cycle that follows that edge.
- Glitch rejection at the sync2 level:
  - A mismatch lasting STABLE_CYCLES-1 cycles is fully rejected.
  - A mismatch lasting STABLE_CYCLES cycles is accepted.
- Channels are fully independent. Simultaneous events on different channels are all handled in the same cycle.
- Rise and fall are never both high on the same channel.
- The counter never wraps: it saturates by construction at STABLE_CYCLES-1.
- Reset asserted mid-SETTLING: the partial count is discarded and no pulse is produced.
- Reset released while the pin differs from INIT_LEVEL: a full debounce is performed, then the normal pulse.
- Reset released while the pin equals INIT_LEVEL: no pulse.
- No combinational path from button_in to any output.

Decomposition:
- Shared board include: the FSM state encodings STATE_STABLE=1'b0 and STATE_SETTLING=1'b1, plus a helper that computes STABLE_CYCLES with the clamp to 1.
- Sub-module debounce_channel: one synchronizer, one counter, one FSM and the pulse registers, with parameter STABLE_CYCLES.
- button_debouncer instantiates CHANNELS copies of debounce_channel in a generate loop.

Test Plan:
All scenarios use CLOCK_FREQUENCY=1000000, DEBOUNCE_TIME_US=4 (STABLE_CYCLES=4) and CHANNELS=2. INIT_LEVEL is 2'b00 unless stated.
1. Clean press: button_in[0] set to 1 and held 20 cycles -> button_level[0] rises on edge 6; button_rise[0] high for exactly 1 cycle; channel 1 outputs stay 0.
2. Bounce: button_in[0] toggles 1,0,1,0 with 2 cycles per value, then is held at 1 -> no output change during the bounce; exactly one rise, on edge 6 counted from the start of the final hold.
3. Glitch boundary: 3-cycle high pulse on button_in[0] -> no change. 4-cycle high pulse -> level goes 1 on edge 6, then a fall pulse after release plus 6 edges.
4. Release: from a debounced level of 1, drop the pin to 0 -> button_fall[0] pulses once on edge 6; button_rise[0] stays 0.
5. Simultaneous, with INIT_LEVEL=2'b10: the same cycle drives button_in to 2'b01 -> on edge 6, rise[0] and fall[1] pulse together and level becomes 2'b01.
6. Reset mid-settle: pin[0]=1, assert reset while the counter is 2 -> level reads 0 immediately with no pulse. Release reset with the pin still 1 -> rise occurs on edge 6 counted from the first post-reset sampling edge.
